// File: rtl/hba_mailbox_pkg.sv
// Shared constants for the HBA mailbox: register offsets, CTRL/STATUS bit
// positions and the transfer-acknowledge state encoding.
package hba_mailbox_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_TX_DATA  = 2;
  localparam int unsigned REG_RX_DATA  = 3;
  localparam int unsigned REG_RX_COUNT = 4;

  localparam int unsigned CTRL_RX_IE  = 0;
  localparam int unsigned CTRL_TXE_IE = 1;
  localparam int unsigned CTRL_CLR    = 7;

  localparam int unsigned ST_RX_EMPTY = 0;
  localparam int unsigned ST_RX_FULL  = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_TX_FULL  = 3;
  localparam int unsigned ST_RX_OVF   = 4;
  localparam int unsigned ST_TX_OVF   = 5;

  typedef enum logic [1:0] {
    ACK_IDLE,
    ACK_ACTIVE,
    ACK_HOLD
  } ack_state_e;

endpackage

// File: rtl/hba_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head, clear, and occupancy.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module hba_sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy next-state; clear overrides any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hba_mailbox.sv
// HBA bus slave exposing a byte mailbox: TX FIFO (bus -> app), RX FIFO
// (app -> bus), control/status registers and a level interrupt.
module hba_mailbox
  import hba_mailbox_pkg::*;
#(
  parameter int unsigned DBUS_WIDTH        = 8,
  parameter int unsigned PERIPH_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int unsigned PERIPH_ADDR       = 0,
  parameter int unsigned FIFO_AW           = 4
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] slave_dbus,
  output logic                  slave_xferack,
  output logic                  slave_interrupt,
  output logic [7:0]            app_tx_data,
  output logic                  app_tx_valid,
  input  logic                  app_tx_ready,
  input  logic [7:0]            app_rx_data,
  input  logic                  app_rx_valid
);

  ack_state_e                state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic                      rnw_q, rnw_d;
  logic [7:0]                wdata_q, wdata_d;
  logic [1:0]                ctrl_q, ctrl_d;
  logic                      rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic                      irq_q, irq_d;

  logic              hit, ack, wr, rd;
  logic              sel_ctrl, sel_status, sel_tx, sel_rx, sel_cnt;
  logic              clr, tx_push, tx_pop, rx_push, rx_pop, stat_rd;
  logic [FIFO_AW:0]  tx_count, rx_count;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]        rx_head, status, rdata;

  assign hit = hba_select &
               (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));

  // Ack FSM: one ack per transfer. A select still held after the ack parks
  // in HOLD so it is not seen as a fresh transfer.
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    rnw_d   = rnw_q;
    wdata_d = wdata_q;
    case (state_q)
      ACK_IDLE: if (hit) begin
        state_d = ACK_ACTIVE;
        reg_d   = hba_abus[REG_ADDR_WIDTH-1:0];
        rnw_d   = hba_rnw;
        wdata_d = hba_dbus;
      end
      ACK_ACTIVE: state_d = hba_select ? ACK_HOLD : ACK_IDLE;
      ACK_HOLD:   if (!hba_select) state_d = ACK_IDLE;
      default:    state_d = ACK_IDLE;
    endcase
  end

  assign ack        = (state_q == ACK_ACTIVE);
  assign wr         = ack & ~rnw_q;
  assign rd         = ack & rnw_q;
  assign sel_ctrl   = (reg_q == REG_ADDR_WIDTH'(REG_CTRL));
  assign sel_status = (reg_q == REG_ADDR_WIDTH'(REG_STATUS));
  assign sel_tx     = (reg_q == REG_ADDR_WIDTH'(REG_TX_DATA));
  assign sel_rx     = (reg_q == REG_ADDR_WIDTH'(REG_RX_DATA));
  assign sel_cnt    = (reg_q == REG_ADDR_WIDTH'(REG_RX_COUNT));

  assign tx_full  = tx_count[FIFO_AW];
  assign tx_empty = (tx_count == '0);
  assign rx_full  = rx_count[FIFO_AW];
  assign rx_empty = (rx_count == '0);

  assign clr     = wr & sel_ctrl & wdata_q[CTRL_CLR];
  assign tx_push = wr & sel_tx;
  assign tx_pop  = app_tx_valid & app_tx_ready;
  assign rx_push = app_rx_valid;
  assign rx_pop  = rd & sel_rx & ~rx_empty;
  assign stat_rd = rd & sel_status;

  hba_sync_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk(hba_clk), .rst_n(hba_reset_n), .clr(clr), .push(tx_push), .pop(tx_pop),
    .wdata(wdata_q), .rdata(app_tx_data), .count(tx_count)
  );

  hba_sync_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk(hba_clk), .rst_n(hba_reset_n), .clr(clr), .push(rx_push), .pop(rx_pop),
    .wdata(app_rx_data), .rdata(rx_head), .count(rx_count)
  );

  assign app_tx_valid = ~tx_empty;

  // Control, sticky overflow flags and interrupt next-state. A new overflow
  // beats a same-cycle STATUS read-clear; a FIFO clear beats both.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr && sel_ctrl) ctrl_d = {wdata_q[CTRL_TXE_IE], wdata_q[CTRL_RX_IE]};
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    if (stat_rd) begin
      rx_ovf_d = 1'b0;
      tx_ovf_d = 1'b0;
    end
    if (rx_push && rx_full && !rx_pop) rx_ovf_d = 1'b1;
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (clr) begin
      rx_ovf_d = 1'b0;
      tx_ovf_d = 1'b0;
    end
    irq_d = (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TXE_IE] & tx_empty);
  end

  // Read data mux; driven onto the bus only during the ack cycle.
  always_comb begin
    status = '0;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_OVF]   = rx_ovf_q;
    status[ST_TX_OVF]   = tx_ovf_q;
    rdata = '0;
    if (sel_ctrl)   rdata = {6'b0, ctrl_q};
    if (sel_status) rdata = status;
    if (sel_rx)     rdata = rx_empty ? 8'h00 : rx_head;
    if (sel_cnt)    rdata = 8'(rx_count);
  end

  assign slave_dbus      = ack ? rdata : '0;
  assign slave_xferack   = ack;
  assign slave_interrupt = irq_q;

  // Top-level state registers.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q  <= ACK_IDLE;
      reg_q    <= '0;
      rnw_q    <= 1'b0;
      wdata_q  <= '0;
      ctrl_q   <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_q    <= reg_d;
      rnw_q    <= rnw_d;
      wdata_q  <= wdata_d;
      ctrl_q   <= ctrl_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_hba_mailbox.sv
// Directed bench for hba_mailbox: register table plus hand-written
// FIFO, overflow, interrupt and handshake sequences.
module tb_hba_mailbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] abus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  dbus = '0;
  logic [7:0]  sdbus;
  logic        ack;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hba_mailbox #(.PERIPH_ADDR(0), .FIFO_AW(4)) dut (
    .hba_clk(clk), .hba_reset_n(rst_n), .hba_abus(abus), .hba_rnw(rnw),
    .hba_select(sel), .hba_dbus(dbus), .slave_dbus(sdbus), .slave_xferack(ack),
    .slave_interrupt(irq), .app_tx_data(tx_data), .app_tx_valid(tx_valid),
    .app_tx_ready(tx_ready), .app_rx_data(rx_data), .app_rx_valid(rx_valid)
  );

  typedef struct {
    logic       rnw;
    logic [7:0] rg;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus transfer; returns one cycle after the ack with side effects applied.
  task automatic xfer(input logic r, input logic [7:0] rg, input logic [7:0] wd,
                      output logic [7:0] rdv);
    logic got;
    got = 1'b0;
    rdv = 8'h00;
    @(negedge clk);
    abus = {4'h0, rg};
    rnw  = r;
    dbus = wd;
    sel  = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        rdv = sdbus;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic app_push(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    int         acks;
    logic [7:0] dor;

    vecs[0]  = '{1'b1, 8'd1, 8'h00, 8'h05};
    vecs[1]  = '{1'b1, 8'd0, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 8'd0, 8'h83, 8'h00};
    vecs[3]  = '{1'b1, 8'd0, 8'h00, 8'h03};
    vecs[4]  = '{1'b1, 8'd2, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 8'd4, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 8'd3, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 8'd9, 8'hFF, 8'h00};
    vecs[8]  = '{1'b1, 8'd9, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, 8'd0, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 8'd0, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 8'd1, 8'h00, 8'h05};

    // Reset state
    #12;
    check("rst_ack", 32'(ack), 0);
    check("rst_dbus", 32'(sdbus), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_txvalid", 32'(tx_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register table
    foreach (vecs[i]) begin
      xfer(vecs[i].rnw, vecs[i].rg, vecs[i].wdata, r);
      if (vecs[i].rnw) check($sformatf("vec%0d_rd", i), 32'(r), 32'(vecs[i].exp));
    end

    // Single TX write reaches the app side
    xfer(1'b0, 8'd2, 8'h41, r);
    check("tx_valid", 32'(tx_valid), 1);
    check("tx_data", 32'(tx_data), 32'h41);
    @(negedge clk); tx_ready = 1'b1;
    @(posedge clk); #1; tx_ready = 1'b0;
    check("tx_popped", 32'(tx_valid), 0);

    // RX path: three pushes, count, ordered reads, empty read
    app_push(8'h10); app_push(8'h11); app_push(8'h12);
    xfer(1'b1, 8'd4, 8'h00, r); check("rx_count3", 32'(r), 32'h03);
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 8'd3, 8'h00, r); check($sformatf("rx_rd%0d", i), 32'(r), 32'(8'h10 + i));
    end
    xfer(1'b1, 8'd3, 8'h00, r); check("rx_rd_empty", 32'(r), 0);
    xfer(1'b1, 8'd1, 8'h00, r); check("status_rx_empty", 32'(r), 32'h05);

    // TX overflow: 17 writes without app pops
    for (int i = 0; i < 17; i++) xfer(1'b0, 8'd2, 8'(8'h80 + i), r);
    xfer(1'b1, 8'd1, 8'h00, r); check("status_txovf", 32'(r), 32'h29);
    xfer(1'b1, 8'd1, 8'h00, r); check("status_txovf_clr", 32'(r), 32'h09);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("tx_pop%0d", i), {23'b0, tx_valid, tx_data}, {24'h1, 8'(8'h80 + i)});
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    check("tx_drained", 32'(tx_valid), 0);

    // RX full: same-cycle app push and bus pop
    for (int i = 0; i < 16; i++) app_push(8'(8'h20 + i));
    xfer(1'b1, 8'd4, 8'h00, r); check("rx_count16", 32'(r), 32'h10);
    @(negedge clk);
    abus = 12'h003; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #1;
    check("collide_ack", 32'(ack), 1);
    check("collide_data", 32'(sdbus), 32'h20);
    @(negedge clk);
    sel = 1'b0; rx_data = 8'h55; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    xfer(1'b1, 8'd4, 8'h00, r); check("collide_count", 32'(r), 32'h10);
    xfer(1'b1, 8'd1, 8'h00, r); check("collide_no_ovf", 32'(r), 32'h06);
    app_push(8'h66);
    xfer(1'b1, 8'd1, 8'h00, r); check("rx_ovf_set", 32'(r), 32'h16);
    xfer(1'b1, 8'd1, 8'h00, r); check("rx_ovf_clr", 32'(r), 32'h06);
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 8'd3, 8'h00, r);
      check($sformatf("rx_order%0d", i), 32'(r), (i == 15) ? 32'h55 : 32'(8'h21 + i));
    end

    // CTRL clear empties both FIFOs
    app_push(8'hA1); app_push(8'hA2);
    xfer(1'b0, 8'd2, 8'h99, r);
    xfer(1'b0, 8'd0, 8'h80, r);
    xfer(1'b1, 8'd4, 8'h00, r); check("clr_count", 32'(r), 0);
    xfer(1'b1, 8'd1, 8'h00, r); check("clr_status", 32'(r), 32'h05);
    check("clr_txvalid", 32'(tx_valid), 0);

    // Interrupt on RX not empty
    xfer(1'b0, 8'd0, 8'h01, r);
    @(posedge clk); #1;
    check("irq_idle", 32'(irq), 0);
    app_push(8'h77);
    @(posedge clk); #1;
    check("irq_set", 32'(irq), 1);
    xfer(1'b1, 8'd3, 8'h00, r); check("irq_rd", 32'(r), 32'h77);
    @(posedge clk); #1;
    check("irq_clear", 32'(irq), 0);
    xfer(1'b0, 8'd0, 8'h00, r);

    // Select held 4 cycles -> one ack
    acks = 0;
    @(negedge clk);
    abus = 12'h001; rnw = 1'b1; sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    @(negedge clk); sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check("held_one_ack", 32'(acks), 1);

    // Other peripheral -> no ack, bus stays zero
    acks = 0; dor = 8'h00;
    @(negedge clk);
    abus = 12'h501; rnw = 1'b1; sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
      dor = dor | sdbus;
    end
    @(negedge clk); sel = 1'b0;
    check("other_no_ack", 32'(acks), 0);
    check("other_dbus0", 32'(dor), 0);

    // Reset during ack drops it immediately
    @(negedge clk);
    abus = 12'h000; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(ack), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ack", 32'(ack), 0);
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    xfer(1'b1, 8'd1, 8'h00, r); check("post_rst_status", 32'(r), 32'h05);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
